// File: rtl/if_pkg.sv
// Shared defaults and types for the instruction-fetch stage and its fetch queue.
package if_pkg;

    localparam int IF_PC_W   = 32;
    localparam int IF_INS_W  = 32;
    localparam int IF_IMEM_AW = 7;

    localparam int unsigned RESET_PC = 0;

    // Queue entry at the default widths; parametrised instances build the same layout locally.
    typedef struct packed {
        logic [IF_PC_W-1:0]  pc_p1;
        logic [IF_INS_W-1:0] ins;
    } fq_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Generic synchronous FIFO with a separate occupancy counter; flush beats push and pop.
module if_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push_i & ~flush_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~flush_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch with a small queue towards decode; redirects flush the queue and reload the PC.
// Define IF_FQ_BYPASS_EN to present the current fetch directly to decode when the queue is empty.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int PC_W     = IF_PC_W,
    parameter int IMEM_AW  = IF_IMEM_AW,
    parameter int INS_W    = IF_INS_W,
    parameter int FQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_valid,
    input  logic [PC_W-1:0]             redirect_pc,
    output logic [IMEM_AW-1:0]          imem_addr,
    input  logic [INS_W-1:0]            imem_rdata,
    output logic                        out_valid,
    output logic [INS_W-1:0]            out_ins,
    output logic [PC_W-1:0]             out_pc_p1,
    input  logic                        out_ready,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    typedef struct packed {
        logic [PC_W-1:0]  pc_p1;
        logic [INS_W-1:0] ins;
    } entry_t;

    logic [PC_W-1:0] pc_q, pc_d, pc_p1;
    entry_t          head, push_ent;
    logic            full, empty, fifo_pop, fetch_en, push;

    assign pc_p1     = pc_q + PC_W'(1);
    assign imem_addr = pc_q[IMEM_AW-1:0];
    assign push_ent  = '{pc_p1: pc_p1, ins: imem_rdata};

    assign fifo_pop  = ~empty & out_ready;
    assign fetch_en  = ~redirect_valid & (~full | fifo_pop);

`ifdef IF_FQ_BYPASS_EN
    logic bypass;
    // An empty queue exposes the fetch in flight; if decode takes it, it never enters the queue.
    assign bypass    = empty & ~redirect_valid;
    assign push      = fetch_en & ~(bypass & out_ready);
    assign out_valid = ~empty | bypass;
    assign out_ins   = bypass ? imem_rdata : head.ins;
    assign out_pc_p1 = bypass ? pc_p1 : head.pc_p1;
`else
    assign push      = fetch_en;
    assign out_valid = ~empty;
    assign out_ins   = head.ins;
    assign out_pc_p1 = head.pc_p1;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc;
        else if (fetch_en)  pc_d = pc_p1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= PC_W'(RESET_PC);
        else        pc_q <= pc_d;
    end

    if_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .din_i   (push_ent),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fq_count),
        .head_o  (head)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (default build) with a combinational imem model imem[i]=0x1000+i.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_ins;
    logic [31:0] out_pc_p1;
    logic        out_ready;
    logic [2:0]  fq_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h1000 + {25'd0, imem_addr};

    if_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ins        (out_ins),
        .out_pc_p1      (out_pc_p1),
        .out_ready      (out_ready),
        .fq_count       (fq_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] ins, input logic [31:0] pcp1);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_ins"}, {32'd0, out_ins}, {32'd0, ins});
        chk({tag, "_pcp1"}, {32'd0, out_pc_p1}, {32'd0, pcp1});
    endtask

    task automatic reset_release(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = ready;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        #12;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_count", {61'd0, fq_count}, 64'd0);
        chk("rst_addr", {57'd0, imem_addr}, 64'd0);

        // Streaming with decode always ready
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_head("s0", 32'h1000, 32'd1);
        chk("s0_count", {61'd0, fq_count}, 64'd1);
        step();
        chk_head("s1", 32'h1001, 32'd2);
        chk("s1_count", {61'd0, fq_count}, 64'd1);
        step();
        chk_head("s2", 32'h1002, 32'd3);

        // Asynchronous reset mid-operation, then backpressure
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_count", {61'd0, fq_count}, 64'd0);
        chk("arst_addr", {57'd0, imem_addr}, 64'd0);
        reset_release(1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("full_count", {61'd0, fq_count}, 64'd4);
        chk("full_addr", {57'd0, imem_addr}, 64'd4);
        chk_head("full_head", 32'h1000, 32'd1);
        out_ready = 1'b1;
        step();
        chk_head("d1", 32'h1001, 32'd2);
        chk("d1_count", {61'd0, fq_count}, 64'd4);
        chk("d1_addr", {57'd0, imem_addr}, 64'd5);
        step();
        chk_head("d2", 32'h1002, 32'd3);
        step();
        chk_head("d3", 32'h1003, 32'd4);
        step();
        chk_head("d4", 32'h1004, 32'd5);

        // Redirect with two entries queued
        reset_release(1'b0);
        step();
        step();
        chk("pre_rd_count", {61'd0, fq_count}, 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        chk("rd_valid", {63'd0, out_valid}, 64'd0);
        chk("rd_count", {61'd0, fq_count}, 64'd0);
        chk("rd_addr", {57'd0, imem_addr}, 64'h40);
        redirect_valid = 1'b0;
        step();
        chk_head("rd_tgt", 32'h1040, 32'h41);
        chk("rd_tgt_count", {61'd0, fq_count}, 64'd1);
        step();
        step();
        step();
        chk("rf_count", {61'd0, fq_count}, 64'd4);
        chk("rf_addr", {57'd0, imem_addr}, 64'h44);

        // Redirect on a full queue while decode pops the head
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        chk("rfp_valid", {63'd0, out_valid}, 64'd0);
        chk("rfp_count", {61'd0, fq_count}, 64'd0);
        chk("rfp_addr", {57'd0, imem_addr}, 64'h10);
        redirect_valid = 1'b0;
        step();
        chk_head("rfp_t0", 32'h1010, 32'h11);
        chk("rfp_t0_count", {61'd0, fq_count}, 64'd1);
        step();
        chk_head("rfp_t1", 32'h1011, 32'h12);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        chk("wr_valid", {63'd0, out_valid}, 64'd0);
        chk("wr_addr", {57'd0, imem_addr}, 64'h7F);
        redirect_valid = 1'b0;
        step();
        chk_head("wr_top", 32'h107F, 32'd0);
        chk("wr_addr0", {57'd0, imem_addr}, 64'd0);
        step();
        chk_head("wr_zero", 32'h1000, 32'd1);

        // Back-to-back redirects: only the last target is fetched
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_pc    = 32'h30;
        step();
        chk("bb_valid", {63'd0, out_valid}, 64'd0);
        chk("bb_count", {61'd0, fq_count}, 64'd0);
        chk("bb_addr", {57'd0, imem_addr}, 64'h30);
        redirect_valid = 1'b0;
        step();
        chk_head("bb_tgt", 32'h1030, 32'h31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage with a small fetch queue between the PC/instruction-memory path and decode.
- Fetches one word-addressed instruction per cycle into the queue, with PC incremented by 1 per instruction.
- Decode pops entries with a valid/ready handshake.
- A branch/jump redirect flushes the queue and reloads the PC.
- Replaces the single-register fetch stage; decode stalls now map to backpressure instead of freezing the PC directly.

Parameters:
- PC_W, 32, PC width in bits (word address).
- IMEM_AW, 7, instruction-memory address width; low IMEM_AW bits of PC drive the memory.
- INS_W, 32, instruction width.
- FQ_DEPTH, 4, fetch-queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  taken branch/jump from later stage.
- redirect_pc  in  PC_W  target PC for the redirect.
- imem_addr  out  IMEM_AW  asynchronous-read instruction-memory address (PC[IMEM_AW-1:0]).
- imem_rdata  in  INS_W  instruction read data, combinational from imem_addr.
- out_valid  out  1  queue head valid.
- out_ins  out  INS_W  head instruction.
- out_pc_p1  out  PC_W  head instruction's PC+1.
- out_ready  in  1  decode accepts head this cycle.
- fq_count  out  clog2(FQ_DEPTH)+1  current occupancy (debug/perf).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset values: PC=0, queue empty, fq_count=0, out_valid=0. out_ins and out_pc_p1 read the head slot and are don't-care while out_valid=0.
- Handshake:
  - pop = out_valid & out_ready.
  - fetch_en = ~redirect_valid & (count < FQ_DEPTH | pop).
- Fetch: on fetch_en the entry {PC+1, imem_rdata} is pushed at the tail and PC <= PC+1. PC addition wraps modulo 2^PC_W.
- Latency:
  - PC value to out_valid is 1 cycle.
  - First out_valid rises on the first clk edge after rst_n deasserts. Entry PC=0 appears with out_pc_p1=1.
- Full queue:
  - Full and no pop: no push, PC holds, imem_addr holds.
  - Full with pop: push and pop in the same cycle, count unchanged.
- Empty queue: out_valid=0 and out_ready is ignored.
- Redirect (priority over everything):
  - At the edge, the queue is cleared (count=0, pointers reset) and PC <= redirect_pc.
  - No push that cycle.
  - A head popped in the same cycle counts as consumed by decode.
  - out_valid=0 in the following cycle, and the target instruction appears 1 cycle after that.
- Back-to-back redirects: each redirect overrides the previous one; only the last target is fetched.
- Pointer wrap: read and write pointers wrap modulo FQ_DEPTH. Count is separate, so full and empty are unambiguous.
- Reset mid-operation: all state returns to the reset values immediately (asynchronously), with no partial pushes.
- Output stability: out_ins and out_pc_p1 stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- IF_FQ_BYPASS_EN defined:
  - When the queue is empty and redirect_valid=0, out_valid=1 combinationally.
  - out_ins=imem_rdata and out_pc_p1=PC+1 are taken from the current fetch.
  - If out_ready=1, PC advances and nothing is pushed. Otherwise the entry is pushed normally.
  - Fetch-to-decode latency becomes 0 cycles, matching a single-cycle fetch.
- Undefined: all outputs come from the registered queue, with 1-cycle latency.

Decomposition:
- Package if_pkg:
  - Default PC_W, INS_W and IMEM_AW constants.
  - fq_entry_t struct {pc_p1, ins}.
  - RESET_PC constant (0).
- Sub-module if_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH.
  - Interface: push, pop, flush, full, empty, count, head.
  - Flush has priority over push.
- if_fetch_queue holds the PC register, fetch_en/redirect logic and the bypass mux.

Test Plan:
- Reset release, imem[i]=0x1000+i, out_ready=1 → out_valid rises after 1 edge; heads are (0x1000,1), (0x1001,2), (0x1002,3) on consecutive cycles.
- out_ready=0 for 10 cycles from reset → fq_count reaches 4, then PC holds at 4. Raising out_ready drains entries 0..3, then 4 follows with no gap.
- Redirect at cycle 6 to redirect_pc=0x40 with the queue holding 2 entries → next cycle out_valid=0, fq_count=0; the cycle after gives out_pc_p1=0x41, ins=imem[0x40].
- Redirect asserted with full queue and out_ready=1 on the same cycle → head counted as consumed, queue empty, PC=target; no stale entry is ever presented.
- PC=2^PC_W-1 via redirect → fetched entry has out_pc_p1=0, and PC wraps to 0.
- IF_FQ_BYPASS_EN, out_ready=1 from reset → out_valid=1 in the first cycle with out_pc_p1=1, and fq_count stays 0 throughout.
